// File: rtl/frame_strobe_writer_if.sv
// Request channel from the bitstream loader into frame_strobe_writer.
// The master drives a frame write and the slave answers with req_ready.
interface frame_strobe_writer_if #(
    parameter int CW = 2,
    parameter int FW = 5,
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_col;
    logic [FW-1:0] req_frame;
    logic [DW-1:0] req_data;

    modport master (
        output req_valid,
        output req_col,
        output req_frame,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_col,
        input  req_frame,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/frame_strobe_writer.sv
// Column frame latch driver: one-hot FrameStrobe pulse with programmable setup/width/hold.
// Optional FRAME_STROBE_RANGE_CHECK_EN rejects out-of-range requests with an err pulse.
module frame_strobe_writer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumColumns      = 4,
    parameter int SetupCycles     = 1,
    parameter int StrobeCycles    = 1,
    parameter int HoldCycles      = 1
) (
    input  logic                                  CLK,
    input  logic                                  resetn,
    frame_strobe_writer_if.slave                  req,
    output logic [FrameBitsPerRow-1:0]            FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  err
);
    localparam int CW = (NumColumns > 1) ? $clog2(NumColumns) : 1;
    localparam int FW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam int SW = NumColumns * MaxFramesPerCol;

    localparam logic [7:0] SETUP_N  = 8'(SetupCycles - 1);
    localparam logic [7:0] STROBE_N = 8'(StrobeCycles - 1);
    localparam logic [7:0] HOLD_N   = 8'(HoldCycles - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    logic [1:0]    state;
    logic [7:0]    cnt;
    logic [CW-1:0] col_q;
    logic [FW-1:0] frame_q;
    logic [SW-1:0] strobe_dec;
    logic          go;

    assign req.req_ready = resetn && (state == IDLE);
    assign busy          = (state != IDLE);

    // An out-of-range target decodes to an all-zero strobe.
    always_comb begin
        strobe_dec = '0;
        if (int'(col_q) < NumColumns && int'(frame_q) < MaxFramesPerCol)
            strobe_dec = SW'(1) << (int'(col_q) * MaxFramesPerCol + int'(frame_q));
    end

`ifdef FRAME_STROBE_RANGE_CHECK_EN
    logic in_range;

    assign in_range = (int'(req.req_col) < NumColumns)
                   && (int'(req.req_frame) < MaxFramesPerCol);
    assign go       = req.req_valid && in_range;

    always_ff @(posedge CLK) begin
        if (!resetn)
            err <= 1'b0;
        else
            err <= req.req_valid && req.req_ready && !in_range;
    end
`else
    assign go  = req.req_valid;
    assign err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            col_q       <= '0;
            frame_q     <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state     <= SETUP;
                        cnt       <= SETUP_N;
                        col_q     <= req.req_col;
                        frame_q   <= req.req_frame;
                        FrameData <= req.req_data;
                    end
                end
                SETUP: begin
                    if (cnt == 8'd0) begin
                        state       <= STROBE;
                        cnt         <= STROBE_N;
                        FrameStrobe <= strobe_dec;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 8'd0) begin
                        state       <= HOLD;
                        cnt         <= HOLD_N;
                        FrameStrobe <= '0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 8'd0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
            endcase
        end
    end
endmodule
